// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and limits for the programmable clock divider.
package clk_div_pkg;
    localparam int DIV_W_DEF       = 16;
    localparam int DEFAULT_DIV_DEF = 8;
    localparam int MIN_DIV         = 2;
endpackage

// File: rtl/prog_clk_divider_if.sv
// prog_clk_divider_if: divisor load/enable/sync controls and divided outputs for all channels.
interface prog_clk_divider_if import clk_div_pkg::*; #(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = DIV_W_DEF
);
    logic [CHANNELS*DIV_W-1:0] div_in;
    logic [CHANNELS-1:0]       div_load;
    logic [CHANNELS-1:0]       en;
    logic                      sync;
    logic [CHANNELS-1:0]       out;
    logic [CHANNELS-1:0]       tick;
    modport master (output div_in, div_load, en, sync, input out, tick);
    modport slave  (input div_in, div_load, en, sync, output out, tick);
endinterface

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel with glitch-free divisor update at period boundaries.
module clk_div_channel import clk_div_pkg::*; #(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    input  logic             en,
    output logic             out,
    output logic             tick
);
    logic [DIV_W-1:0] cnt, d_act, d_shadow, d_eff, d_next;
    logic [DIV_W:0]   half;
    logic             wrap;

    always_comb begin
        d_eff  = (d_act < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d_act;
        half   = ({1'b0, d_eff} + (DIV_W+1)'(1)) >> 1;
        d_next = div_load ? div_in : d_shadow;
        wrap   = cnt == d_eff - DIV_W'(1);
    end

    // d_act only moves at a period boundary, so a running waveform never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            out      <= 1'b0;
            tick     <= 1'b0;
            d_act    <= DIV_W'(DEFAULT_DIV);
            d_shadow <= DIV_W'(DEFAULT_DIV);
        end else begin
            if (div_load) d_shadow <= div_in;
            if (!en) begin
                cnt   <= '0;
                out   <= 1'b0;
                tick  <= 1'b0;
                d_act <= d_next;
            end else if (sync) begin
                cnt   <= DIV_W'(1);
                out   <= 1'b1;
                tick  <= 1'b1;
                d_act <= d_next;
            end else begin
                out  <= {1'b0, cnt} < half;
                tick <= cnt == '0;
                cnt  <= wrap ? '0 : cnt + DIV_W'(1);
                if (wrap) d_act <= d_next;
            end
        end
    end
endmodule

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: CHANNELS independent programmable clock dividers sharing one sync strobe.
module prog_clk_divider import clk_div_pkg::*; #(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input logic               clk,
    input logic               rst,
    prog_clk_divider_if.slave bus
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        clk_div_channel #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .sync    (bus.sync),
            .div_in  (bus.div_in[i*DIV_W +: DIV_W]),
            .div_load(bus.div_load[i]),
            .en      (bus.en[i]),
            .out     (bus.out[i]),
            .tick    (bus.tick[i])
        );
    end
endmodule

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent divider channels (1..16).
REQ-002 Parameter DIV_W, default 16, width of each divisor value.
REQ-003 Parameter DEFAULT_DIV, default 8, divisor loaded at reset (2..2^DIV_W-1).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 div_in  input  CHANNELS*DIV_W  per-channel divisor; channel i in bits [i*DIV_W +: DIV_W].
REQ-007 div_load  input  CHANNELS  per-channel one-cycle strobe capturing div_in slice into shadow register.
REQ-008 en  input  CHANNELS  per-channel run enable.
REQ-009 sync  input  1  one-cycle strobe re-phasing all enabled channels.
REQ-010 out  output  CHANNELS  registered divided waveform per channel.
REQ-011 tick  output  CHANNELS  registered one-cycle pulse coincident with each rising edge of out.

Function
REQ-012 Per channel: registers cnt (DIV_W), d_act (active divisor), d_shadow (pending divisor); D_eff = max(d_act, 2).
REQ-013 div_load SHALL write div_in slice to d_shadow on that edge; d_next = div_load ? div_in slice : d_shadow.
REQ-014 Enabled cycle: out <= (cnt < ceil(D_eff/2)); tick <= (cnt == 0); cnt <= (cnt == D_eff-1) ? 0 : cnt+1.
REQ-015 Period SHALL be exactly D_eff clk cycles; high phase ceil(D_eff/2), low phase floor(D_eff/2) (odd D: high one cycle longer).
REQ-016 Divisor change SHALL be glitch-free: d_act <= d_next only at wrap (cnt == D_eff-1), when disabled, or on sync; never mid-period.
REQ-017 load coincident with wrap: new divisor SHALL take effect on the period starting next cycle.
REQ-018 Divisor 0 or 1 SHALL behave as 2 (clk/2, 50% duty).
REQ-019 en low: cnt <= 0, out <= 0, tick <= 0, d_act <= d_next; shadow still loadable.
REQ-020 en rising: out and tick SHALL assert on the edge after the first cycle en is sampled high (latency 1 cycle).
REQ-021 en falling mid-period: out SHALL drop on the next edge (no period completion).
REQ-022 sync on an enabled channel: cnt <= 1, out <= 1, tick <= 1, d_act <= d_next (identical to start of new period); sync overrides wrap and load timing.
REQ-023 sync on a disabled channel SHALL have no effect other than as REQ-019.
REQ-024 Channels SHALL be fully independent except for shared sync.
REQ-025 No combinational path from any input to out or tick.

Reset
REQ-026 rst SHALL set per channel: cnt=0, out=0, tick=0, d_act=d_shadow=DEFAULT_DIV.
REQ-027 rst SHALL take priority over en, sync, div_load in the same cycle.
REQ-028 rst asserted mid-period SHALL abort the period; after release channel behaves as freshly enabled (REQ-020).

Structure
REQ-029 Package clk_div_pkg SHALL hold DIV_W default, DEFAULT_DIV default, and minimum divisor constant 2.
REQ-030 One sub-module clk_div_channel (one channel: cnt, d_act, d_shadow, out, tick) SHALL be instantiated CHANNELS times via generate.
REQ-031 Top SHALL contain only slicing of div_in and fan-out of clk, rst, sync.

Verification
REQ-032 DEFAULT_DIV=8, en=1 after rst: out 4 high/4 low, period 8, tick once per period aligned to out rising.
REQ-033 Load 5 at cnt=2 of a div-8 period: current period completes at 8 cycles, then 3 high/2 low periods of 5.
REQ-034 Load 0, then 1: both yield period 2, out toggling every cycle, tick every 2 cycles.
REQ-035 ch0 div 6, ch1 div 9, free-running, pulse sync: both tick and out rise on the next edge, periods 6 and 9 thereafter.
REQ-036 en low at cnt=3 of div 8: out low next edge, tick stays 0; en high again: out/tick rise one cycle later.
REQ-037 rst asserted with div_load=1, div_in=3 and sync=1 same cycle: d_act=d_shadow=8, out=0; post-reset period 8.
